// File: rtl/fmap_column_reader.sv
`default_nettype none
// ============================================================================
// Module   : fmap_column_reader
// Purpose  : Streams a stored feature map out of its result BRAM as 3-row
//            vertical columns for a downstream 3x3 systolic convolution.
//            After the producer reports done, every 3-row band is walked
//            top to bottom, left to right, under ready/valid backpressure.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               request a full read pass (ignored while busy)
//   src_done            producer has finished writing the map
//   rd_addr0/1/2        BRAM read addresses for band rows r, r+1, r+2
//   rd_data0/1/2        BRAM read data, one cycle after the address
//   col_out             column: low lane = row r, middle = r+1, top = r+2
//   col_valid/col_ready column handshake
//   row_end             column is the last one of a band
//   last                column is the final column of the pass
//   busy                pass in progress (WAIT, RUN or DRAIN)
//   done                pass complete, held until the next accepted start
// Build option
//   FMAP_READER_SAT_EN  defined   : lanes saturate to 2^OUT_WIDTH-1
//                       undefined : lanes are the low OUT_WIDTH bits
// ============================================================================
module fmap_column_reader #(
   parameter int DATA_WIDTH = 22,
   parameter int OUT_WIDTH  = 8,
   parameter int IMG_W      = 222,
   parameter int IMG_H      = 222,
   parameter int ADDR_WIDTH = 18
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   src_done,
   output logic [ADDR_WIDTH-1:0]  rd_addr0,
   output logic [ADDR_WIDTH-1:0]  rd_addr1,
   output logic [ADDR_WIDTH-1:0]  rd_addr2,
   input  logic [DATA_WIDTH-1:0]  rd_data0,
   input  logic [DATA_WIDTH-1:0]  rd_data1,
   input  logic [DATA_WIDTH-1:0]  rd_data2,
   output logic [3*OUT_WIDTH-1:0] col_out,
   output logic                   col_valid,
   input  logic                   col_ready,
   output logic                   row_end,
   output logic                   last,
   output logic                   busy,
   output logic                   done
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_WAIT  = 3'd1;
   localparam logic [2:0] c_RUN   = 3'd2;
   localparam logic [2:0] c_DRAIN = 3'd3;
   localparam logic [2:0] c_DONE  = 3'd4;

   localparam int c_CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int c_RW = (IMG_H > 3) ? $clog2(IMG_H - 2) : 1;
   localparam int c_EW = 3 * OUT_WIDTH + 2;   // lanes + row_end + last

   localparam logic [c_CW-1:0] c_C_LAST = c_CW'(IMG_W - 1);
   localparam logic [c_RW-1:0] c_R_LAST = c_RW'(IMG_H - 3);

`ifdef FMAP_READER_SAT_EN
   localparam logic [DATA_WIDTH-1:0] c_LANE_MAX = DATA_WIDTH'((1 << OUT_WIDTH) - 1);
`endif

   // -------------------------------------------------------------------------
   // Declarations
   // -------------------------------------------------------------------------
   logic [2:0]            state_q, state_d;
   logic [c_CW-1:0]       c_q;
   logic [c_RW-1:0]       r_q;
   logic [ADDR_WIDTH-1:0] addr0_q, addr1_q, addr2_q;

   logic                  inflight_q;
   logic                  infl_row_end_q;
   logic                  infl_last_q;

   logic [c_EW-1:0]       fifo_q [2];
   logic                  wr_ptr_q, rd_ptr_q;
   logic [1:0]            count_q, count_d;

   logic                  w_run;
   logic                  w_load;
   logic                  w_pop;
   logic                  w_push;
   logic [2:0]            w_occ;
   logic                  w_issue;
   logic                  w_row_end;
   logic                  w_final;
   logic [3*OUT_WIDTH-1:0] w_lanes;
   logic [c_EW-1:0]       w_entry;

   // -------------------------------------------------------------------------
   // Lane conversion, applied as the returning word is written to the FIFO
   // -------------------------------------------------------------------------
   function automatic logic [OUT_WIDTH-1:0] f_lane(input logic [DATA_WIDTH-1:0] word);
`ifdef FMAP_READER_SAT_EN
      if (word > c_LANE_MAX) begin
         return {OUT_WIDTH{1'b1}};
      end
      return word[OUT_WIDTH-1:0];
`else
      return word[OUT_WIDTH-1:0];
`endif
   endfunction

   assign w_lanes = {f_lane(rd_data2), f_lane(rd_data1), f_lane(rd_data0)};
   assign w_entry = {infl_last_q, infl_row_end_q, w_lanes};

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= c_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE, c_DONE: begin
            if (start) state_d = c_WAIT;
         end
         c_WAIT: begin
            if (src_done) state_d = c_RUN;
         end
         c_RUN: begin
            if (w_issue && w_final) state_d = c_DRAIN;
         end
         c_DRAIN: begin
            // Look at the post-cycle occupancy so that done rises the cycle
            // right after the final column is accepted. Any read still in
            // flight is a push this cycle and keeps count_d non-zero.
            if (count_d == 2'd0) state_d = c_DONE;
         end
         default: state_d = c_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs
   // -------------------------------------------------------------------------
   always_comb begin
      busy  = 1'b0;
      done  = 1'b0;
      w_run = 1'b0;
      case (state_q)
         c_WAIT, c_DRAIN: busy = 1'b1;
         c_RUN: begin
            busy  = 1'b1;
            w_run = 1'b1;
         end
         c_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign w_load = (state_q == c_WAIT) && src_done;

   // -------------------------------------------------------------------------
   // Read issue: a new read is allowed only if the FIFO can absorb it once
   // the outstanding read and this cycle's pop are accounted for.
   // -------------------------------------------------------------------------
   assign w_pop     = col_valid & col_ready;
   assign w_push    = inflight_q;
   assign w_occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
   assign w_issue   = w_run && (w_occ < 3'd2);
   assign w_row_end = (c_q == c_C_LAST);
   assign w_final   = w_row_end && (r_q == c_R_LAST);

   // -------------------------------------------------------------------------
   // Band/column counters and read addresses.
   // The map is row-major, so base + c is contiguous across a band wrap
   // (base + IMG_W-1 is followed by (base + IMG_W) + 0): every address
   // simply steps by one per issued read, with no multiply.
   // The final read does not step, so the ports keep the last address.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         c_q     <= '0;
         r_q     <= '0;
         addr0_q <= '0;
         addr1_q <= '0;
         addr2_q <= '0;
      end else if (w_load) begin
         c_q     <= '0;
         r_q     <= '0;
         addr0_q <= '0;
         addr1_q <= ADDR_WIDTH'(IMG_W);
         addr2_q <= ADDR_WIDTH'(2 * IMG_W);
      end else if (w_issue && !w_final) begin
         if (w_row_end) begin
            c_q <= '0;
            r_q <= r_q + 1'b1;
         end else begin
            c_q <= c_q + 1'b1;
         end
         addr0_q <= addr0_q + 1'b1;
         addr1_q <= addr1_q + 1'b1;
         addr2_q <= addr2_q + 1'b1;
      end
   end

   assign rd_addr0 = addr0_q;
   assign rd_addr1 = addr1_q;
   assign rd_addr2 = addr2_q;

   // -------------------------------------------------------------------------
   // In-flight tracking: flags travel alongside the read so they can be
   // attached to the column when its data returns.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q     <= 1'b0;
         infl_row_end_q <= 1'b0;
         infl_last_q    <= 1'b0;
      end else begin
         inflight_q     <= w_issue;
         infl_row_end_q <= w_issue && w_row_end;
         infl_last_q    <= w_issue && w_final;
      end
   end

   // -------------------------------------------------------------------------
   // Two-entry column FIFO. The head entry drives the outputs directly, so
   // a stalled column is held stable until it is accepted.
   // -------------------------------------------------------------------------
   assign count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};

   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
      end else begin
         if (w_push) begin
            fifo_q[wr_ptr_q] <= w_entry;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (w_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   assign {last, row_end, col_out} = fifo_q[rd_ptr_q];
   assign col_valid                = (count_q != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_fmap_column_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmap_column_reader
// Purpose  : Directed self-checking bench for fmap_column_reader on a 4x4 map
//            whose BRAM model returns data equal to the address.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fmap_column_reader;

   localparam int DW   = 22;
   localparam int OW   = 8;
   localparam int IW   = 4;
   localparam int IH   = 4;
   localparam int AW   = 8;
   localparam int NCOL = (IH - 2) * IW;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            src_done;
   logic            col_ready;
   logic [AW-1:0]   rd_addr0, rd_addr1, rd_addr2;
   logic [DW-1:0]   rd_data0, rd_data1, rd_data2;
   logic [3*OW-1:0] col_out;
   logic            col_valid, row_end, last, busy, done;

   logic [DW-1:0]   mem [256];
   logic [3*OW-1:0] got_cols [NCOL];
   logic [OW-1:0]   sat_exp;

   int n_cmp = 0;
   int n_err = 0;
   int fc;

   fmap_column_reader #(
      .DATA_WIDTH (DW),
      .OUT_WIDTH  (OW),
      .IMG_W      (IW),
      .IMG_H      (IH),
      .ADDR_WIDTH (AW)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .src_done  (src_done),
      .rd_addr0  (rd_addr0),
      .rd_addr1  (rd_addr1),
      .rd_addr2  (rd_addr2),
      .rd_data0  (rd_data0),
      .rd_data1  (rd_data1),
      .rd_data2  (rd_data2),
      .col_out   (col_out),
      .col_valid (col_valid),
      .col_ready (col_ready),
      .row_end   (row_end),
      .last      (last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Synchronous-read BRAM model: data one cycle after the address.
   always @(posedge clk) begin
      rd_data0 <= mem[rd_addr0];
      rd_data1 <= mem[rd_addr1];
      rd_data2 <= mem[rd_addr2];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [OW-1:0] lane(input logic [DW-1:0] w);
`ifdef FMAP_READER_SAT_EN
      return (w > 22'd255) ? 8'd255 : w[OW-1:0];
`else
      return w[OW-1:0];
`endif
   endfunction

   // For a 4-wide map, band r column c reads row-major address k = 4r + c
   // on the bottom lane, k+4 on the middle lane and k+8 on the top lane.
   function automatic logic [3*OW-1:0] exp_col(input int k);
      return {lane(mem[k + 8]), lane(mem[k + 4]), lane(mem[k])};
   endfunction

   // Consumes nexp columns, checking content, flags and hold-under-stall.
   task automatic collect(input int rnd, input int nexp, input int pulse_at,
                          output int first_cyc);
      int                got    = 0;
      int                cyc    = 0;
      logic              held_v = 1'b0;
      logic [3*OW+1:0]   held   = '0;
      first_cyc = -1;
      while (got < nexp && cyc < 300) begin
         @(negedge clk);
         cyc++;
         start     = (cyc == pulse_at);
         col_ready = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
         if (held_v) begin
            chk("bp_valid", col_valid, 1);
            chk("bp_hold", {last, row_end, col_out}, held);
         end
         held_v = 1'b0;
         if (col_valid) begin
            if (col_ready) begin
               if (first_cyc < 0) first_cyc = cyc;
               got_cols[got] = col_out;
               chk($sformatf("col%0d", got), col_out, exp_col(got));
               chk($sformatf("row_end%0d", got), row_end, ((got % IW) == IW - 1));
               chk($sformatf("last%0d", got), last, (got == NCOL - 1));
               got++;
            end else begin
               held_v = 1'b1;
               held   = {last, row_end, col_out};
            end
         end
      end
      start = 1'b0;
      if (got < nexp) chk("xfer_count", got, nexp);
   endtask

   task automatic check_done(input string tag);
      @(negedge clk);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic start_pass();
      @(negedge clk);
      start     = 1'b1;
      src_done  = 1'b1;
      col_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int moved;
      int seen;
      rst       = 1'b1;
      start     = 1'b0;
      src_done  = 1'b0;
      col_ready = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = DW'(i);
`ifdef FMAP_READER_SAT_EN
      sat_exp = 8'd255;
`else
      sat_exp = 8'd44;
`endif

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_addr0", rd_addr0, 0);
      chk("rst_addr1", rd_addr1, 0);
      chk("rst_addr2", rd_addr2, 0);
      chk("rst_col", col_out, 0);
      chk("rst_valid", col_valid, 0);
      chk("rst_row_end", row_end, 0);
      chk("rst_last", last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;

      // Test 1: start with src_done high, ready held, latency check
      @(negedge clk);
      col_ready = 1'b1;
      start     = 1'b1;
      src_done  = 1'b1;
      @(negedge clk);                      // t+1, WAIT
      start = 1'b0;
      chk("t1_busy_wait", busy, 1);
      chk("t1_valid_wait", col_valid, 0);
      @(negedge clk);                      // t+2, RUN, first address
      chk("t1_addr0", rd_addr0, 0);
      chk("t1_addr1", rd_addr1, 4);
      chk("t1_addr2", rd_addr2, 8);
      @(negedge clk);                      // t+3, data returning
      chk("t1_valid_t3", col_valid, 0);
      collect(0, NCOL, -1, fc);            // t+4 is the first iteration
      chk("t1_first_latency", fc, 1);
      check_done("t1");

      // Test 2: start while src_done low, hold in WAIT for 10 cycles
      @(negedge clk);
      start    = 1'b1;
      src_done = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("t2_done_clear", done, 0);
      moved = 0;
      seen  = 0;
      repeat (10) begin
         @(negedge clk);
         if (rd_addr0 !== 8'd7 || rd_addr1 !== 8'd11 || rd_addr2 !== 8'd15) moved++;
         if (col_valid !== 1'b0) seen++;
      end
      chk("t2_addr_hold", moved, 0);
      chk("t2_no_valid", seen, 0);
      src_done = 1'b1;
      collect(0, NCOL, -1, fc);
      chk("t2_first_latency", fc, 3);
      check_done("t2");

      // Test 3: random 50% ready
      start_pass();
      collect(1, NCOL, -1, fc);
      check_done("t3");

      // Test 4: start pulse while busy is ignored
      start_pass();
      collect(0, NCOL, 4, fc);
      check_done("t4");
      repeat (3) @(negedge clk);
      chk("t4_still_done", done, 1);
      chk("t4_no_valid", col_valid, 0);

      // Test 5: reset after the 3rd transfer, then a full pass again
      start_pass();
      collect(0, 3, -1, fc);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_addr0", rd_addr0, 0);
      chk("t5_addr1", rd_addr1, 0);
      chk("t5_addr2", rd_addr2, 0);
      chk("t5_col", col_out, 0);
      chk("t5_valid", col_valid, 0);
      chk("t5_row_end", row_end, 0);
      chk("t5_last", last, 0);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      rst = 1'b0;
      start_pass();
      collect(0, NCOL, -1, fc);
      check_done("t5");

      // Test 6: stored word 300 (row 1, col 1 -> address 5)
      mem[5] = 22'd300;
      start_pass();
      collect(0, NCOL, -1, fc);
      chk("t6_lane_mid", got_cols[1][2*OW-1:OW], sat_exp);
      chk("t6_lane_low", got_cols[5][OW-1:0], sat_exp);
      check_done("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/fmap_column_reader.md
# fmap_column_reader

Streams a stored convolution feature map back out of its output BRAM as 3-row vertical columns, the input format the next 3x3 systolic convolution stage consumes. Sits between a conv layer's result BRAM and the next layer's column input, driving the BRAM's three read ports. Waits for the producing layer's `done`, then walks every 3-row band top to bottom, left to right, under ready/valid backpressure.

## Interface
Parameters:
- `DATA_WIDTH`, 22: width of one stored BRAM word.
- `OUT_WIDTH`, 8: width of one output lane.
- `IMG_W`, 222: feature-map width in words.
- `IMG_H`, 222: feature-map height in rows; must be ≥3.
- `ADDR_WIDTH`, 18: BRAM address width; `IMG_W*IMG_H` must fit.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a full read pass.
- `src_done`  in  1  producer layer has finished writing the map.
- `rd_addr0`/`rd_addr1`/`rd_addr2`  out  ADDR_WIDTH  BRAM read addresses for band rows r, r+1 and r+2.
- `rd_data0`/`rd_data1`/`rd_data2`  in  DATA_WIDTH  BRAM read data, valid one cycle after the address.
- `col_out`  out  3*OUT_WIDTH  column: `[OUT_WIDTH-1:0]` = row r, middle lane = r+1, top lane = r+2.
- `col_valid`  out  1  `col_out` holds a valid column.
- `col_ready`  in  1  consumer accepts the column. A transfer happens when `col_valid & col_ready`.
- `row_end`  out  1  qualifies `col_out`: last column (c = IMG_W-1) of a band.
- `last`  out  1  qualifies `col_out`: final column of the final band.
- `busy`  out  1  state is WAIT, RUN or DRAIN.
- `done`  out  1  pass complete; held high until the next accepted `start`.

## Operation
- FSM states: IDLE, WAIT, RUN, DRAIN, DONE.
  - IDLE or DONE with `start`: go to WAIT. `done` clears.
  - WAIT with `src_done`: go to RUN. Band counter r, column counter c and base address are zeroed.
  - RUN: issue reads. When the read for (r = IMG_H-3, c = IMG_W-1) is issued, go to DRAIN.
  - DRAIN: when no read is in flight and the FIFO is empty, go to DONE.
  - `start` is ignored while `busy`.
- Addresses: `rd_addr0` = base + c, `rd_addr1` = base + IMG_W + c, `rd_addr2` = base + 2*IMG_W + c.
  - base advances by IMG_W at each band wrap.
  - No multipliers are used.
  - Outside RUN, the address outputs hold their last value.
- Buffering: a 2-entry FIFO holds columns, each with its `row_end` and `last` flags.
  - In-flight is 1 if a read was issued in the previous cycle.
  - A read is issued in a RUN cycle iff `fifo_count + inflight - pop < 2`, where pop = `col_valid & col_ready`.
  - Issue advances c. At c = IMG_W-1, c wraps to 0 and r increments.
- Lane conversion is applied per word when the word is written into the FIFO (see Configuration).
- Total columns per pass: (IMG_H-2)*IMG_W. Exactly one of them has `last` set.

## Timing
- Reset values: `rd_addr*` = 0, `col_out` = 0, `col_valid` = 0, `row_end` = 0, `last` = 0, `busy` = 0, `done` = 0. The FIFO and in-flight tracking are flushed.
- `rst` mid-pass: the in-flight read is discarded and the FSM returns to IDLE on the next edge.
- `start` and `src_done` both sampled high in IDLE at cycle t:
  - WAIT in t+1, RUN in t+2.
  - The first address is presented in t+2, data returns in t+3, and `col_valid` rises in t+4.
- With `col_ready` held high: one column per cycle with no bubbles, including across band wraps.
- `col_valid` low with `col_ready` high is legal.
- Backpressure: once `col_valid` rises it stays high with `col_out`, `row_end` and `last` stable until accepted. No column is lost or duplicated.
- `done` rises the cycle after the `last` column transfers. `busy` falls in the same cycle.

## Configuration
- `FMAP_READER_SAT_EN` defined: each lane = min(word, 2^OUT_WIDTH-1), an unsigned saturation.
- Undefined: each lane = `word[OUT_WIDTH-1:0]`, a plain truncation.

## Test plan
- Use IMG_W=4, IMG_H=4, and a BRAM model where the data equals the address. Hold `col_ready` high and pulse `start` with `src_done` high.
  - Required: 8 columns, the first `{8,4,0}` and the last `{15,11,7}`.
  - `row_end` on columns 3 and 7; `last` only on column 7.
  - `done` is high one cycle after the last transfer.
- Raise `start` with `src_done` low for 10 cycles, then raise `src_done`.
  - Required: no address changes and no `col_valid` until RUN. The column sequence is then identical to the first test.
- Drive `col_ready` with a random 50% duty pattern.
  - Required: the same 8 columns in order, and `col_out` stable whenever `col_valid` is high and `col_ready` is low.
- Store word 300 in the model.
  - With `FMAP_READER_SAT_EN` defined: the lane reads 255.
  - Without it: the lane reads 44.
- Assert `rst` after the 3rd transfer.
  - Required: all outputs return to their reset values next cycle.
  - A new `start` then reproduces the full sequence from `{8,4,0}`.
- Pulse `start` while `busy`.
  - Required: the pulse is ignored and the output sequence is unchanged.
